// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch with credit-limited imem reads, in-order queue and redirect squashing
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] ins_out,
    output logic        ins_valid
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QUEUE_DEPTH);
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] q_pc_q [QUEUE_DEPTH];
    logic [31:0] q_pc_d [QUEUE_DEPTH];
    logic [31:0] q_ins_q [QUEUE_DEPTH];
    logic [31:0] q_ins_d [QUEUE_DEPTH];
    logic [31:0] tag_q [QUEUE_DEPTH];
    logic [31:0] tag_d [QUEUE_DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, discard_q, discard_d;
    logic issue, push;
    // Outputs: credit-gated request, head of queue presented while decode can take it
    always_comb begin
        imem_req  = !rst && !redirect && (count_q + inflight_q < DEPTH);
        imem_addr = fetch_pc_q;
        issue     = imem_req && imem_gnt;
        ins_valid = (count_q != '0) && !stall && !redirect;
        pc_out    = count_q != '0 ? q_pc_q[head_q] : '0;
        ins_out   = count_q != '0 ? q_ins_q[head_q] : '0;
        push      = imem_rvalid && discard_q == '0 && !redirect;
    end
    // Next state: redirect flushes the queue and marks every request still in flight as stale
    always_comb begin
        fetch_pc_d = redirect ? (redirect_pc & ~32'h3) : issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        inflight_d = inflight_q + CW'(issue) - CW'(imem_rvalid);
        discard_d  = redirect ? inflight_d : discard_q - CW'(imem_rvalid && discard_q != '0);
        count_d    = redirect ? '0 : count_q + CW'(push) - CW'(ins_valid);
        head_d     = redirect ? '0 : head_q + AW'(ins_valid);
        tail_d     = redirect ? '0 : tail_q + AW'(push);
        tag_wr_d   = tag_wr_q + AW'(issue);
        tag_rd_d   = tag_rd_q + AW'(imem_rvalid);
        q_pc_d     = q_pc_q;
        q_ins_d    = q_ins_q;
        tag_d      = tag_q;
        if (push) begin
            q_pc_d[tail_q]  = tag_q[tag_rd_q];
            q_ins_d[tail_q] = imem_rdata;
        end
        if (issue) tag_d[tag_wr_q] = fetch_pc_q;
    end
    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            q_pc_q     <= '{default: '0};
            q_ins_q    <= '{default: '0};
            tag_q      <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            q_pc_q     <= q_pc_d;
            q_ins_q    <= q_ins_d;
            tag_q      <= tag_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end
endmodule
